ahb_sram_slave: RTL and testbench

AHB-Lite responder that terminates transfers issued by the CPU-side AHB bus master and backs them with an internal word-organized SRAM array. It decodes byte, halfword and word accesses into byte-lane writes and returns full 32-bit words on reads. Wait-state insertion is programmable. Out-of-range and misaligned accesses receive a two-cycle ERROR response. It sits behind the bus matrix as a generic memory slave for on-chip RAM and for bench stimulus.

---
 rtl/ahb_sram_slave.sv | 69 ++++++
 tb/tb_ahb_sram_slave.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder backed by a word-organized SRAM array,
// with programmable wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        RES_SYS,
  input  logic        S_HSEL,
  input  logic [1:0]  S_HTRANS,
  input  logic        S_HWRITE,
  input  logic        S_HMASTLOCK,
  input  logic [2:0]  S_HSIZE,
  input  logic [2:0]  S_HBURST,
  input  logic [3:0]  S_HPROT,
  input  logic [31:0] S_HADDR,
  input  logic [31:0] S_HWDATA,
  input  logic        S_HREADY,
  output logic        S_HREADYOUT,
  output logic [31:0] S_HRDATA,
  output logic        S_HRESP
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, nxt;
  logic [3:0] cnt, cnt_d, be_q, be_d;
  logic [AW-1:0] addr_q;
  logic wr_q, accept, bad, take, unused_ok;
  logic [31:0] mem [MEM_WORDS];
  assign accept = S_HSEL & S_HREADY & S_HTRANS[1];
  assign bad = S_HADDR >= 32'(MEM_WORDS * 4) || S_HSIZE > 3'b010 ||
               (S_HSIZE == 3'b001 && S_HADDR[0]) ||
               (S_HSIZE == 3'b010 && S_HADDR[1:0] != 2'b00);
  assign take = accept && (state == S_IDLE || state == S_DATA || state == S_ERR2);
  assign be_d = S_HSIZE == 3'b000 ? 4'b0001 << S_HADDR[1:0] :
                S_HSIZE == 3'b001 ? (S_HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign unused_ok = ^{S_HMASTLOCK, S_HBURST, S_HPROT, S_HTRANS[0]};
  always_comb begin
    nxt = take ? (bad ? S_ERR1 : (WAIT_CYCLES > 0 ? S_WAIT : S_DATA)) :
          state == S_ERR1 ? S_ERR2 :
          state == S_WAIT ? (cnt == 4'd0 ? S_DATA : S_WAIT) : S_IDLE;
    cnt_d = take ? 4'(WAIT_CYCLES - 1) :
            (state == S_WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge CLK or negedge RES_SYS)
    if (!RES_SYS) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      be_q   <= 4'd0;
      wr_q   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_d;
      if (take && !bad) begin
        addr_q <= S_HADDR[AW+1:2];
        be_q   <= be_d;
        wr_q   <= S_HWRITE;
      end
    end
  // Write commits on the edge ending DATA, so a read accepted on that edge sees merged data.
  always_ff @(posedge CLK)
    if (state == S_DATA && wr_q)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[addr_q][8*i +: 8] <= S_HWDATA[8*i +: 8];
  assign S_HREADYOUT = !(state == S_WAIT || state == S_ERR1);
  assign S_HRESP     = state == S_ERR1 || state == S_ERR2;
  assign S_HRDATA    = state == S_DATA ? mem[addr_q] : 32'd0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: pipelined AHB master driving a zero-wait and a 3-wait instance,
// with a scoreboard of expected data-phase responses.
module tb_ahb_sram_slave;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] sel = 2'b00, htrans = 2'b00;
  logic hwrite = 1'b0;
  logic [2:0] hsize = 3'd0;
  logic [31:0] haddr = 32'd0, hwdata = 32'd0;
  wire [1:0] rdy, resp;
  wire [31:0] rd0, rd1;
  int n_chk = 0, n_fail = 0, lowc = 0;
  typedef struct {int tgt; logic wr; logic err; logic [31:0] data; int waits; string tag;} exp_t;
  exp_t sb[$];
  exp_t cur;
  logic [31:0] mdl [int];
  always #5 clk = ~clk;
  ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .CLK(clk), .RES_SYS(rst_n), .S_HSEL(sel[0]), .S_HTRANS(htrans), .S_HWRITE(hwrite),
    .S_HMASTLOCK(1'b0), .S_HSIZE(hsize), .S_HBURST(3'd0), .S_HPROT(4'd3), .S_HADDR(haddr),
    .S_HWDATA(hwdata), .S_HREADY(rdy[0]), .S_HREADYOUT(rdy[0]), .S_HRDATA(rd0), .S_HRESP(resp[0]));
  ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(3)) u3 (
    .CLK(clk), .RES_SYS(rst_n), .S_HSEL(sel[1]), .S_HTRANS(htrans), .S_HWRITE(hwrite),
    .S_HMASTLOCK(1'b0), .S_HSIZE(hsize), .S_HBURST(3'd0), .S_HPROT(4'd3), .S_HADDR(haddr),
    .S_HWDATA(hwdata), .S_HREADY(rdy[1]), .S_HREADYOUT(rdy[1]), .S_HRDATA(rd1), .S_HRESP(resp[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a, input logic [2:0] s);
    return a >= 32'h1000 || s > 3'd2 || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [2:0] s, input logic [1:0] o);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s == 3'd2 || (s == 3'd1 && (i >> 1) == int'(o[1])) || (s == 3'd0 && i == int'(o)))
        r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic issue(input int t, input logic w, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] d, input string tag, input logic abort = 1'b0);
    exp_t e;
    int k, key;
    sel = 2'(1 << t); htrans = 2'b10; hwrite = w; hsize = s; haddr = a;
    k = 0;
    while (!rdy[t] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check({tag, "_accept_timeout"}, 32'(rdy[t]), 32'd1);
    @(posedge clk);
    #1;
    if (w) hwdata = d;
    if (!abort) begin
      e.tgt = t; e.wr = w; e.err = is_bad(a, s); e.tag = tag;
      e.waits = e.err ? 1 : (t == 1 ? 3 : 0);
      key = t * 4096 + int'(a[11:2]);
      if (!e.err && w) mdl[key] = merge(mdl.exists(key) ? mdl[key] : 32'd0, d, s, a[1:0]);
      e.data = (!e.err && mdl.exists(key)) ? mdl[key] : 32'd0;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    sel = 2'b00; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk)
    if (rst_n && sb.size() > 0) begin
      cur = sb[0];
      if (!rdy[cur.tgt]) begin
        lowc++;
        check({cur.tag, "_low_resp"}, 32'(resp[cur.tgt]), 32'(cur.err));
      end else begin
        check({cur.tag, "_resp"}, 32'(resp[cur.tgt]), 32'(cur.err));
        check({cur.tag, "_waits"}, 32'(lowc), 32'(cur.waits));
        if (!cur.wr && !cur.err)
          check({cur.tag, "_rdata"}, cur.tgt == 1 ? rd1 : rd0, cur.data);
        void'(sb.pop_front());
        lowc = 0;
      end
    end

  initial begin
    #12;
    check("rst_rdy", 32'(rdy), 32'd3);
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_rdata1", rd1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 1, 3'd2, 32'h10, 32'h12345678, "w10");
    issue(0, 0, 3'd2, 32'h10, 32'd0, "r10");
    issue(0, 1, 3'd0, 32'h11, 32'hAAAAAAAA, "wb11");
    issue(0, 0, 3'd2, 32'h10, 32'd0, "r10_byte");
    issue(0, 1, 3'd1, 32'h12, 32'hBEEFBEEF, "wh12");
    issue(0, 0, 3'd2, 32'h10, 32'd0, "r10_half");
    issue(0, 1, 3'd2, 32'h0, 32'h5A5A0001, "w00");
    issue(0, 0, 3'd2, 32'h1000, 32'd0, "oor_read");
    issue(0, 1, 3'd2, 32'h2, 32'hDEADDEAD, "mis_word");
    issue(0, 1, 3'd1, 32'h1, 32'hDEADDEAD, "mis_half");
    issue(0, 0, 3'd3, 32'h4, 32'd0, "bad_size");
    issue(0, 0, 3'd2, 32'h0, 32'd0, "r00_intact");
    issue(0, 1, 3'd2, 32'h20, 32'hCAFEF00D, "w20");
    issue(0, 0, 3'd2, 32'h20, 32'd0, "fwd20");
    issue(0, 1, 3'd0, 32'h23, 32'h77777777, "wb23");
    issue(0, 0, 3'd2, 32'h20, 32'd0, "fwd20_byte");
    idle();
    drain();
    sel = 2'b01; htrans = 2'b00;
    @(posedge clk);
    #1;
    check("idle_sel_rdy", 32'(rdy[0]), 32'd1);
    check("idle_sel_resp", 32'(resp[0]), 32'd0);
    idle();
    issue(1, 1, 3'd2, 32'h40, 32'h11111111, "w3_40");
    issue(1, 0, 3'd2, 32'h40, 32'd0, "r3_40");
    issue(1, 0, 3'd2, 32'h40, 32'd0, "r3_40_b2b");
    issue(1, 0, 3'd2, 32'h1000, 32'd0, "w3_oor");
    issue(1, 0, 3'd2, 32'h40, 32'd0, "r3_after_err");
    idle();
    drain();
    issue(1, 1, 3'd2, 32'h40, 32'h22222222, "abort", 1'b1);
    idle();
    #1;
    check("abort_in_wait", 32'(rdy[1]), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rdy", 32'(rdy[1]), 32'd1);
    check("abort_resp", 32'(resp[1]), 32'd0);
    check("abort_rdata", rd1, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 0, 3'd2, 32'h40, 32'd0, "r3_post_rst");
    idle();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
